// File: rtl/acc_ctrl.sv
// Accumulator control stage: buffers (op, operand) instructions, drives an external ALU and
// returns each new accumulator value on a valid/ready port. Define ACC_FLAGS_EN for z/n/v flags.
module acc_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_op,
    input  logic [3:0] in_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [3:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_v
);

    // state  | meaning
    // IDLE   | no instruction in flight, waiting for the FIFO to fill
    // EXEC   | ALU driven from op/data registers, acc captured at the edge
    // RESULT | res_valid high, holding acc until the consumer takes it

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESULT
    } state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    acc;
    logic          push;
    logic          pop;
    logic          fifo_ne;

    assign in_ready = (count != DEPTH_C);
    assign fifo_ne  = (count != '0);
    assign push     = in_valid && in_ready;
    // Pop only from registered occupancy, so a fresh push is never bypassed.
    assign pop      = fifo_ne && ((state == IDLE) || ((state == RESULT) && res_ready));

    assign alu_b    = acc;
    assign res_data = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_op, in_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            alu_a     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        {alu_op, alu_a} <= mem[rd_ptr];
                        state           <= EXEC;
                    end
                end
                EXEC: begin
                    acc       <= alu_out;
                    res_valid <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop) begin
                            {alu_op, alu_a} <= mem[rd_ptr];
                            state           <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ACC_FLAGS_EN
    logic fz;
    logic fn;
    logic fv;
    logic ovf;

    // alu_a is the operand, alu_b the accumulator: overflow is judged against acc's sign.
    always_comb begin
        ovf = 1'b0;
        case (alu_op)
            4'd0:    ovf = (alu_a[3] == alu_b[3]) && (alu_out[3] != alu_b[3]);
            4'd1:    ovf = (alu_a[3] != alu_b[3]) && (alu_out[3] != alu_b[3]);
            default: ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fz <= 1'b0;
            fn <= 1'b0;
            fv <= 1'b0;
        end else if (state == EXEC) begin
            fz <= (alu_out == 4'd0);
            fn <= alu_out[3];
            fv <= ovf;
        end
    end

    assign flag_z = fz;
    assign flag_n = fn;
    assign flag_v = fv;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
    assign flag_v = 1'b0;
`endif

endmodule
